irq_sequencer: RTL and testbench

CPU-side counterpart of the vectored interrupt controller (VIC). It consumes the VIC request (o_VIC_ctrl / o_VIC_iaddr), drains the pipeline and stacks the return PC and condition codes. It then redirects fetch to the handler and acknowledges the VIC. On a decoded RETI it pops the stack, restores PC and condition codes, and pulses the VIC's i_reti input.

---
 rtl/irq_sequencer.sv | 146 ++++++++++++++
 tb/tb_irq_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// CPU-side interrupt sequencer: drains the pipeline, stacks PC/flags, vectors to the
// VIC handler and unwinds the stack on RETI. Every output is a flop.
module irq_sequencer #(
    parameter int NEST_DEPTH = 4,
    parameter int PC_W       = 32,
    parameter int CC_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_vic_ctrl,
    input  logic [PC_W-1:0] i_vic_iaddr,
    input  logic [PC_W-1:0] i_pc,
    input  logic [CC_W-1:0] i_ccodes,
    input  logic            i_pipe_idle,
    input  logic            i_reti_dec,
    output logic            o_flush,
    output logic            o_pc_load,
    output logic [PC_W-1:0] o_pc_target,
    output logic            o_ccodes_load,
    output logic [CC_W-1:0] o_ccodes,
    output logic            o_irq_ack,
    output logic            o_reti,
    output logic [2:0]      o_depth,
    output logic [1:0]      o_err
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_VECTOR, S_RETURN} state_e;

    localparam logic [2:0] MAX_DEPTH = 3'(NEST_DEPTH);

    state_e          state_q, state_d;
    logic [2:0]      depth_q, depth_d;
    logic [1:0]      err_q, err_d;
    logic            push;
    logic [2:0]      topIdx;

    logic            flush_d, pcLoad_d, ccLoad_d, ack_d, reti_d;
    logic [PC_W-1:0] pcTarget_d;
    logic [CC_W-1:0] cc_d;

    // Eight slots so the 3-bit depth indexes the array directly; only NEST_DEPTH are used.
    logic [PC_W-1:0] pcStack [8];
    logic [CC_W-1:0] ccStack [8];

    assign topIdx = depth_q - 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            depth_q       <= '0;
            err_q         <= '0;
            o_flush       <= 1'b0;
            o_pc_load     <= 1'b0;
            o_pc_target   <= '0;
            o_ccodes_load <= 1'b0;
            o_ccodes      <= '0;
            o_irq_ack     <= 1'b0;
            o_reti        <= 1'b0;
        end else begin
            state_q       <= state_d;
            depth_q       <= depth_d;
            err_q         <= err_d;
            o_flush       <= flush_d;
            o_pc_load     <= pcLoad_d;
            o_pc_target   <= pcTarget_d;
            o_ccodes_load <= ccLoad_d;
            o_ccodes      <= cc_d;
            o_irq_ack     <= ack_d;
            o_reti        <= reti_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcStack[depth_q] <= i_pc;
            ccStack[depth_q] <= i_ccodes;
        end
    end

    // RETI wins over a pending request so a tail-chained IRQ is taken after the return.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_reti_dec) begin
                    if (depth_q != 3'd0) state_d = S_RETURN;
                    else                 err_d[1] = 1'b1;
                end else if (i_vic_ctrl) begin
                    if (depth_q < MAX_DEPTH) state_d = S_DRAIN;
                    else                     err_d[0] = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!i_vic_ctrl) begin
                    state_d = S_IDLE;
                end else if (i_pipe_idle) begin
                    push    = 1'b1;
                    depth_d = depth_q + 3'd1;
                    state_d = S_VECTOR;
                end
            end
            S_VECTOR: state_d = S_IDLE;
            S_RETURN: begin
                depth_d = depth_q - 3'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they line up with it once registered.
    always_comb begin
        flush_d    = 1'b0;
        pcLoad_d   = 1'b0;
        ccLoad_d   = 1'b0;
        ack_d      = 1'b0;
        reti_d     = 1'b0;
        pcTarget_d = '0;
        cc_d       = '0;
        case (state_d)
            S_DRAIN: flush_d = 1'b1;
            S_VECTOR: begin
                flush_d    = 1'b1;
                pcLoad_d   = 1'b1;
                ack_d      = 1'b1;
                pcTarget_d = i_vic_iaddr;
            end
            S_RETURN: begin
                flush_d    = 1'b1;
                pcLoad_d   = 1'b1;
                ccLoad_d   = 1'b1;
                reti_d     = 1'b1;
                pcTarget_d = pcStack[topIdx];
                cc_d       = ccStack[topIdx];
            end
            default: ;
        endcase
    end

    assign o_depth = depth_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer; PC-load events are matched against a queue of
// expected vector/return events filled as stimulus is applied.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vic_ctrl, i_pipe_idle, i_reti_dec;
    logic [31:0] i_vic_iaddr, i_pc;
    logic [3:0]  i_ccodes;
    logic        o_flush, o_pc_load, o_ccodes_load, o_irq_ack, o_reti;
    logic [31:0] o_pc_target;
    logic [3:0]  o_ccodes;
    logic [2:0]  o_depth;
    logic [1:0]  o_err;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cc;
        bit          isReti;
    } event_t;

    event_t sbq[$];
    event_t ctxStack[$];
    int total = 0;
    int bad   = 0;

    irq_sequencer #(.NEST_DEPTH(4), .PC_W(32), .CC_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_vic_ctrl(i_vic_ctrl), .i_vic_iaddr(i_vic_iaddr),
        .i_pc(i_pc), .i_ccodes(i_ccodes),
        .i_pipe_idle(i_pipe_idle), .i_reti_dec(i_reti_dec),
        .o_flush(o_flush), .o_pc_load(o_pc_load), .o_pc_target(o_pc_target),
        .o_ccodes_load(o_ccodes_load), .o_ccodes(o_ccodes),
        .o_irq_ack(o_irq_ack), .o_reti(o_reti),
        .o_depth(o_depth), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are examined 1ns after the edge and any load strobe is scored.
    task automatic tick();
        event_t e;
        @(posedge clk);
        #1;
        if (o_pc_load === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_load", o_pc_target, 32'hxxxx_xxxx);
            end else begin
                e = sbq.pop_front();
                chk("pc_target", o_pc_target, e.pc);
                chk("irq_ack", {31'd0, o_irq_ack}, {31'd0, !e.isReti});
                chk("reti", {31'd0, o_reti}, {31'd0, e.isReti});
                chk("cc_load", {31'd0, o_ccodes_load}, {31'd0, e.isReti});
                if (e.isReti) chk("ccodes", {28'd0, o_ccodes}, {28'd0, e.cc});
            end
        end else begin
            chk("stray_strobe", {29'd0, o_irq_ack, o_reti, o_ccodes_load}, 32'd0);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        i_vic_ctrl = 1'b0; i_reti_dec = 1'b0; i_pipe_idle = 1'b1;
        i_vic_iaddr = '0; i_pc = '0; i_ccodes = '0;
        sbq.delete();
        ctxStack.delete();
        tick();
        rst = 1'b1;
    endtask

    task automatic takeIrq(input logic [31:0] pc, input logic [3:0] cc, input logic [31:0] vec,
                           input logic [2:0] expDepth);
        i_pc = pc; i_ccodes = cc; i_vic_iaddr = vec; i_vic_ctrl = 1'b1; i_pipe_idle = 1'b1;
        sbq.push_back('{pc: vec, cc: 4'd0, isReti: 1'b0});
        ctxStack.push_back('{pc: pc, cc: cc, isReti: 1'b1});
        tick();
        chk("drain_flush", {31'd0, o_flush}, 32'd1);
        tick();
        chk("vector_flush", {31'd0, o_flush}, 32'd1);
        chk("vector_load", {31'd0, o_pc_load}, 32'd1);
        i_vic_ctrl = 1'b0;
        tick();
        chk("idle_flush", {31'd0, o_flush}, 32'd0);
        chk("depth_after_irq", {29'd0, o_depth}, {29'd0, expDepth});
    endtask

    task automatic doReti(input logic [2:0] expDepth);
        sbq.push_back(ctxStack.pop_back());
        i_reti_dec = 1'b1;
        tick();
        chk("return_load", {31'd0, o_pc_load}, 32'd1);
        i_reti_dec = 1'b0;
        tick();
        chk("depth_after_reti", {29'd0, o_depth}, {29'd0, expDepth});
    endtask

    initial begin
        doReset();
        chk("rst_flush", {31'd0, o_flush}, 32'd0);
        chk("rst_pc_load", {31'd0, o_pc_load}, 32'd0);
        chk("rst_depth", {29'd0, o_depth}, 32'd0);
        chk("rst_err", {30'd0, o_err}, 32'd0);
        tick();

        // Basic entry and return
        takeIrq(32'h100, 4'b1010, 32'h40, 3'd1);
        doReti(3'd0);

        // Four nested levels, a refused fifth, then unwinding in LIFO order
        takeIrq(32'h10, 4'h1, 32'h80, 3'd1);
        takeIrq(32'h20, 4'h2, 32'h84, 3'd2);
        takeIrq(32'h30, 4'h3, 32'h88, 3'd3);
        takeIrq(32'h40, 4'h4, 32'h8c, 3'd4);
        i_vic_ctrl = 1'b1; i_vic_iaddr = 32'h90;
        tick();
        chk("ovf_err", {30'd0, o_err}, 32'd1);
        chk("ovf_no_flush", {31'd0, o_flush}, 32'd0);
        tick();
        chk("ovf_depth", {29'd0, o_depth}, 32'd4);
        i_vic_ctrl = 1'b0;
        doReti(3'd3);
        doReti(3'd2);
        doReti(3'd1);
        doReti(3'd0);
        chk("err_sticky", {30'd0, o_err}, 32'd1);

        // Drain wait with the request withdrawn
        i_pipe_idle = 1'b0; i_vic_ctrl = 1'b1; i_vic_iaddr = 32'h99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain_hold", {31'd0, o_flush}, 32'd1);
        end
        i_vic_ctrl = 1'b0;
        tick();
        chk("withdraw_flush", {31'd0, o_flush}, 32'd0);
        chk("withdraw_depth", {29'd0, o_depth}, 32'd0);
        i_pipe_idle = 1'b1;
        tick();

        // RETI and request together: return first, then the new vector
        takeIrq(32'h200, 4'b0101, 32'h60, 3'd1);
        sbq.push_back(ctxStack.pop_back());
        sbq.push_back('{pc: 32'h70, cc: 4'd0, isReti: 1'b0});
        ctxStack.push_back('{pc: 32'h300, cc: 4'b0011, isReti: 1'b1});
        i_reti_dec = 1'b1; i_vic_ctrl = 1'b1; i_vic_iaddr = 32'h70;
        i_pc = 32'h300; i_ccodes = 4'b0011;
        tick();
        chk("tail_reti_first", {31'd0, o_reti}, 32'd1);
        i_reti_dec = 1'b0;
        tick();
        chk("tail_depth_mid", {29'd0, o_depth}, 32'd0);
        tick();
        chk("tail_drain", {31'd0, o_flush}, 32'd1);
        tick();
        chk("tail_ack", {31'd0, o_irq_ack}, 32'd1);
        i_vic_ctrl = 1'b0;
        tick();
        chk("tail_depth", {29'd0, o_depth}, 32'd1);
        doReti(3'd0);

        // Reset clears sticky errors; underflow on an empty stack
        doReset();
        chk("rst2_err", {30'd0, o_err}, 32'd0);
        i_reti_dec = 1'b1;
        tick();
        chk("udf_err", {30'd0, o_err}, 32'd2);
        chk("udf_no_reti", {31'd0, o_reti}, 32'd0);
        i_reti_dec = 1'b0;
        tick();

        // Asynchronous reset in the middle of a drain
        takeIrq(32'h500, 4'h6, 32'h44, 3'd1);
        i_pipe_idle = 1'b0; i_vic_ctrl = 1'b1;
        tick();
        chk("pre_rst_flush", {31'd0, o_flush}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_flush", {31'd0, o_flush}, 32'd0);
        chk("async_depth", {29'd0, o_depth}, 32'd0);
        chk("async_err", {30'd0, o_err}, 32'd0);
        i_vic_ctrl = 1'b0; i_pipe_idle = 1'b1;
        ctxStack.delete();
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, o_flush}, 32'd0);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
